cmult_pipe_axis: RTL and testbench

//  Parametrised, fully pipelined complex multiplier (a*b or a*conj(b)) with valid/ready

---
 rtl/cmult_pkg.sv | 21 ++
 rtl/cmult_scale_sat.sv | 52 +++++
 rtl/cmult_pipe_axis.sv | 165 ++++++++++++++++
 tb/tb_cmult_pipe_axis.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmult_pkg.sv
// Shared types and constants for the pipelined complex multiplier.
// Optional rounding is selected with the CMULT_ROUND_EN macro (see cmult_scale_sat).
package cmult_pkg;

  // Number of register stages from input handshake to output register.
  localparam int CMULT_LAT = 3;

  // Wide signed complex value, large enough for any legal full-precision result.
  localparam int CMULT_CPLX_W = 64;

  typedef struct packed {
    logic signed [CMULT_CPLX_W-1:0] i;
    logic signed [CMULT_CPLX_W-1:0] q;
  } cplx_t;

  // Full-precision width of one output component: product width plus one carry bit.
  function automatic int full_w(input int in_w);
    return 2 * in_w + 1;
  endfunction

endpackage

// File: rtl/cmult_scale_sat.sv
// Combinational scale, optional round and clamp of one full-precision component.
// Macro CMULT_ROUND_EN: when defined, adds 2^(SHIFT-1) before the arithmetic shift
// (round half toward +inf); otherwise the shift truncates (floor).
module cmult_scale_sat #(
  parameter int FULL_W = 37,
  parameter int OUT_W  = 37,
  parameter int SHIFT  = 0
) (
  input  logic signed [FULL_W-1:0] full_i,
  output logic signed [OUT_W-1:0]  res_o,
  output logic                     sat_o
);

  // One guard bit so the rounding constant can never wrap the sum.
  localparam int EXT_W = FULL_W + 1;

  localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'((EXT_W'(1) << (OUT_W - 1)) - EXT_W'(1));
  localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;

  logic signed [EXT_W-1:0] ext_s;
  logic signed [EXT_W-1:0] rnd_s;
  logic signed [EXT_W-1:0] shr_s;

  assign ext_s = EXT_W'(full_i);

`ifdef CMULT_ROUND_EN
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [EXT_W-1:0] RND_V = (SHIFT > 0) ? EXT_W'(EXT_W'(1) << RND_POS) : EXT_W'(0);
  assign rnd_s = ext_s + RND_V;
`else
  assign rnd_s = ext_s;
`endif

  assign shr_s = rnd_s >>> SHIFT;

  // Clamp the scaled value into the signed OUT_W range and flag any clipping.
  always_comb begin
    res_o = shr_s[OUT_W-1:0];
    sat_o = 1'b0;
    if (shr_s > MAX_V) begin
      res_o = MAX_V[OUT_W-1:0];
      sat_o = 1'b1;
    end else if (shr_s < MIN_V) begin
      res_o = MIN_V[OUT_W-1:0];
      sat_o = 1'b1;
    end else begin
      res_o = shr_s[OUT_W-1:0];
      sat_o = 1'b0;
    end
  end

endmodule

// File: rtl/cmult_pipe_axis.sv
// Three-stage pipelined complex multiplier (a*b or a*conj(b)) with valid/ready on
// both sides. S1 registers operands, S2 registers the four partial products, S3
// combines, scales, rounds (CMULT_ROUND_EN) and saturates into the output register.
module cmult_pipe_axis
  import cmult_pkg::*;
#(
  parameter int IN_W  = 18,
  parameter int OUT_W = 37,
  parameter int SHIFT = 0
) (
  input  logic                    clk_i,
  input  logic                    arstn_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic                    s_conj_i,
  input  logic signed [IN_W-1:0]  s_a_i_i,
  input  logic signed [IN_W-1:0]  s_a_q_i,
  input  logic signed [IN_W-1:0]  s_b_i_i,
  input  logic signed [IN_W-1:0]  s_b_q_i,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic signed [OUT_W-1:0] m_i_o,
  output logic signed [OUT_W-1:0] m_q_o,
  output logic                    m_sat_o
);

  localparam int FULL_W = full_w(IN_W);
  localparam int PROD_W = 2 * IN_W;

  // Reject parameter sets whose output window does not fit the full-precision result.
  if ((OUT_W + SHIFT > FULL_W) || (SHIFT >= FULL_W) || (SHIFT < 0) || (OUT_W < 2)) begin : g_bad_params
    $error("cmult_pipe_axis: illegal OUT_W/SHIFT for the given IN_W");
  end

  // Signed product at full width; the exact result always fits in 2*IN_W bits.
  function automatic logic signed [PROD_W-1:0] smul(input logic signed [IN_W-1:0] x,
                                                    input logic signed [IN_W-1:0] y);
    return PROD_W'(x) * PROD_W'(y);
  endfunction

  // Stage occupancy and load enables.
  logic v1_r, v2_r, v3_r;
  logic ld1_s, ld2_s, ld3_s;

  // S1 operand registers.
  logic signed [IN_W-1:0] a_i_r, a_q_r, b_i_r, b_q_r;
  logic                   conj1_r;

  // S2 partial products.
  logic signed [PROD_W-1:0] p_ii_r, p_qq_r, p_qi_r, p_iq_r;
  logic                     conj2_r;

  // S3 combinational sums and scaled results.
  logic signed [FULL_W-1:0] sum_i_s, sum_q_s;
  logic signed [OUT_W-1:0]  res_i_s, res_q_s;
  logic                     sat_i_s, sat_q_s;

  // S3 output registers.
  logic signed [OUT_W-1:0] out_i_r, out_q_r;
  logic                    sat_r;

  // A stage loads when it is empty or its contents move on; bubbles collapse.
  assign ld3_s = !v3_r || m_ready_i;
  assign ld2_s = !v2_r || ld3_s;
  assign ld1_s = !v1_r || ld2_s;

  assign s_ready_o = ld1_s;
  assign m_valid_o = v3_r;
  assign m_i_o     = out_i_r;
  assign m_q_o     = out_q_r;
  assign m_sat_o   = sat_r;

  // S1: capture operands and conj mode on an input transfer.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      v1_r    <= 1'b0;
      conj1_r <= 1'b0;
      a_i_r   <= '0;
      a_q_r   <= '0;
      b_i_r   <= '0;
      b_q_r   <= '0;
    end else if (ld1_s) begin
      v1_r <= s_valid_i;
      if (s_valid_i) begin
        conj1_r <= s_conj_i;
        a_i_r   <= s_a_i_i;
        a_q_r   <= s_a_q_i;
        b_i_r   <= s_b_i_i;
        b_q_r   <= s_b_q_i;
      end
    end
  end

  // S2: register the four cross products.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      v2_r    <= 1'b0;
      conj2_r <= 1'b0;
      p_ii_r  <= '0;
      p_qq_r  <= '0;
      p_qi_r  <= '0;
      p_iq_r  <= '0;
    end else if (ld2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        conj2_r <= conj1_r;
        p_ii_r  <= smul(a_i_r, b_i_r);
        p_qq_r  <= smul(a_q_r, b_q_r);
        p_qi_r  <= smul(a_q_r, b_i_r);
        p_iq_r  <= smul(a_i_r, b_q_r);
      end
    end
  end

  // S3 combine: conj flips the sign of the b-imaginary contributions.
  always_comb begin
    sum_i_s = '0;
    sum_q_s = '0;
    if (conj2_r) begin
      sum_i_s = FULL_W'(p_ii_r) + FULL_W'(p_qq_r);
      sum_q_s = FULL_W'(p_qi_r) - FULL_W'(p_iq_r);
    end else begin
      sum_i_s = FULL_W'(p_ii_r) - FULL_W'(p_qq_r);
      sum_q_s = FULL_W'(p_qi_r) + FULL_W'(p_iq_r);
    end
  end

  cmult_scale_sat #(
    .FULL_W (FULL_W),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT)
  ) u_scale_i (
    .full_i (sum_i_s),
    .res_o  (res_i_s),
    .sat_o  (sat_i_s)
  );

  cmult_scale_sat #(
    .FULL_W (FULL_W),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT)
  ) u_scale_q (
    .full_i (sum_q_s),
    .res_o  (res_q_s),
    .sat_o  (sat_q_s)
  );

  // S3: output register; holds its value while downstream stalls.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      v3_r    <= 1'b0;
      out_i_r <= '0;
      out_q_r <= '0;
      sat_r   <= 1'b0;
    end else if (ld3_s) begin
      v3_r <= v2_r;
      if (v2_r) begin
        out_i_r <= res_i_s;
        out_q_r <= res_q_s;
        sat_r   <= sat_i_s | sat_q_s;
      end
    end
  end

endmodule

// File: tb/tb_cmult_pipe_axis.sv
// Self-checking bench for cmult_pipe_axis: three instances (default, narrow output with
// large shift, shift-by-one) share one stimulus stream and a scoreboard fed by a
// plain-arithmetic reference model.
module tb_cmult_pipe_axis;
  import cmult_pkg::*;

  localparam int IN_W = 18;
  localparam int OW0 = 37, SH0 = 0;
  localparam int OW1 = 18, SH1 = 17;
  localparam int OW2 = 36, SH2 = 1;

  logic clk_i = 1'b0;
  logic arstn_i, s_valid_i, s_conj_i, m_ready_i;
  logic signed [IN_W-1:0] s_a_i_i, s_a_q_i, s_b_i_i, s_b_q_i;
  logic rdy0, rdy1, rdy2, mv0, mv1, mv2, sat0, sat1, sat2;
  logic signed [OW0-1:0] mi0, mq0;
  logic signed [OW1-1:0] mi1, mq1;
  logic signed [OW2-1:0] mi2, mq2;

  always #5 clk_i = ~clk_i;

  cmult_pipe_axis #(.IN_W(IN_W), .OUT_W(OW0), .SHIFT(SH0)) u_dut0 (
    .clk_i(clk_i), .arstn_i(arstn_i), .s_valid_i(s_valid_i), .s_ready_o(rdy0),
    .s_conj_i(s_conj_i), .s_a_i_i(s_a_i_i), .s_a_q_i(s_a_q_i), .s_b_i_i(s_b_i_i),
    .s_b_q_i(s_b_q_i), .m_valid_o(mv0), .m_ready_i(m_ready_i), .m_i_o(mi0),
    .m_q_o(mq0), .m_sat_o(sat0));

  cmult_pipe_axis #(.IN_W(IN_W), .OUT_W(OW1), .SHIFT(SH1)) u_dut1 (
    .clk_i(clk_i), .arstn_i(arstn_i), .s_valid_i(s_valid_i), .s_ready_o(rdy1),
    .s_conj_i(s_conj_i), .s_a_i_i(s_a_i_i), .s_a_q_i(s_a_q_i), .s_b_i_i(s_b_i_i),
    .s_b_q_i(s_b_q_i), .m_valid_o(mv1), .m_ready_i(m_ready_i), .m_i_o(mi1),
    .m_q_o(mq1), .m_sat_o(sat1));

  cmult_pipe_axis #(.IN_W(IN_W), .OUT_W(OW2), .SHIFT(SH2)) u_dut2 (
    .clk_i(clk_i), .arstn_i(arstn_i), .s_valid_i(s_valid_i), .s_ready_o(rdy2),
    .s_conj_i(s_conj_i), .s_a_i_i(s_a_i_i), .s_a_q_i(s_a_q_i), .s_b_i_i(s_b_i_i),
    .s_b_q_i(s_b_q_i), .m_valid_o(mv2), .m_ready_i(m_ready_i), .m_i_o(mi2),
    .m_q_o(mq2), .m_sat_o(sat2));

  typedef struct packed {
    cplx_t      r0;
    cplx_t      r1;
    cplx_t      r2;
    logic [2:0] sat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   occ    = 0;

  // Scale a full-precision value: optional round, floor shift, clamp.
  function automatic logic signed [63:0] scale(input logic signed [63:0] full, input int sh,
                                               input int ow, output logic sat);
    logic signed [63:0] v, hi, lo;
    v = full;
`ifdef CMULT_ROUND_EN
    if (sh > 0) v = v + (64'sd1 <<< (sh - 1));
`endif
    v  = v >>> sh;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    sat = 1'b0;
    if (v > hi) begin
      v = hi;
      sat = 1'b1;
    end else if (v < lo) begin
      v = lo;
      sat = 1'b1;
    end
    return v;
  endfunction

  // Complex product from the textbook formula, then per-instance scaling.
  function automatic exp_t model(input logic conj, input logic signed [IN_W-1:0] ai,
                                 input logic signed [IN_W-1:0] aq, input logic signed [IN_W-1:0] bi,
                                 input logic signed [IN_W-1:0] bq);
    exp_t e;
    longint xi, xq, yi, yq, fi, fq;
    logic s_i, s_q;
    xi = ai; xq = aq; yi = bi; yq = bq;
    if (conj) begin
      fi = xi * yi + xq * yq;
      fq = xq * yi - xi * yq;
    end else begin
      fi = xi * yi - xq * yq;
      fq = xq * yi + xi * yq;
    end
    e.r0.i = scale(fi, SH0, OW0, s_i); e.r0.q = scale(fq, SH0, OW0, s_q); e.sat[0] = s_i | s_q;
    e.r1.i = scale(fi, SH1, OW1, s_i); e.r1.q = scale(fq, SH1, OW1, s_q); e.sat[1] = s_i | s_q;
    e.r2.i = scale(fi, SH2, OW2, s_i); e.r2.q = scale(fq, SH2, OW2, s_q); e.sat[2] = s_i | s_q;
    return e;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input exp_t e);
    chk("valid1", mv1, 1); chk("valid2", mv2, 1);
    chk("i0", mi0, e.r0.i); chk("q0", mq0, e.r0.q); chk("sat0", sat0, e.sat[0]);
    chk("i1", mi1, e.r1.i); chk("q1", mq1, e.r1.q); chk("sat1", sat1, e.sat[1]);
    chk("i2", mi2, e.r2.i); chk("q2", mq2, e.r2.q); chk("sat2", sat2, e.sat[2]);
  endtask

  // One clock: check readiness and head-of-queue output, update scoreboard, advance.
  task automatic cycle(output logic acc);
    #1;
    chk("s_ready0", rdy0, (occ < 3) || m_ready_i);
    chk("s_ready1", rdy1, (occ < 3) || m_ready_i);
    chk("s_ready2", rdy2, (occ < 3) || m_ready_i);
    if (mv0) begin
      if (sb.size() == 0) chk("spurious_valid", mv0, 0);
      else check_out(sb[0]);
    end
    acc = s_valid_i && rdy0;
    if (mv0 && m_ready_i && sb.size() > 0) begin
      void'(sb.pop_front());
      occ--;
    end
    if (acc) begin
      sb.push_back(model(s_conj_i, s_a_i_i, s_a_q_i, s_b_i_i, s_b_q_i));
      occ++;
    end
    @(posedge clk_i);
    #1;
  endtask

  // Single sample into an empty pipeline: verify latency and constant result on dut0.
  task automatic single(input logic conj, input logic signed [IN_W-1:0] ai, input logic signed [IN_W-1:0] aq,
                        input logic signed [IN_W-1:0] bi, input logic signed [IN_W-1:0] bq,
                        input logic signed [63:0] ei, input logic signed [63:0] eq);
    logic acc;
    s_conj_i = conj; s_a_i_i = ai; s_a_q_i = aq; s_b_i_i = bi; s_b_q_i = bq;
    s_valid_i = 1'b1; m_ready_i = 1'b1;
    cycle(acc);
    chk("accept", acc, 1);
    s_valid_i = 1'b0;
    for (int n = 0; n < CMULT_LAT - 1; n++) begin
      chk("lat_early", mv0, 0);
      cycle(acc);
    end
    chk("lat_valid", mv0, 1);
    chk("const_i", mi0, ei);
    chk("const_q", mq0, eq);
  endtask

  task automatic drain();
    logic acc;
    s_valid_i = 1'b0; m_ready_i = 1'b1;
    for (int n = 0; n < 20 && sb.size() > 0; n++) cycle(acc);
    chk("drained", sb.size(), 0);
  endtask

  task automatic rand_data();
    s_a_i_i = 18'($urandom); s_a_q_i = 18'($urandom);
    s_b_i_i = 18'($urandom); s_b_q_i = 18'($urandom);
    s_conj_i = 1'($urandom);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic saw_low;
    int sent;
    arstn_i = 1'b0; s_valid_i = 1'b0; m_ready_i = 1'b1; s_conj_i = 1'b0;
    s_a_i_i = '0; s_a_q_i = '0; s_b_i_i = '0; s_b_q_i = '0;

    // Reset state.
    #2;
    chk("rst_valid0", mv0, 0); chk("rst_valid1", mv1, 0); chk("rst_valid2", mv2, 0);
    chk("rst_i0", mi0, 0); chk("rst_q0", mq0, 0); chk("rst_sat0", sat0, 0);
    @(posedge clk_i); #3; arstn_i = 1'b1;
    @(posedge clk_i); #1;
    chk("ready_after_rst", rdy0, 1);

    // 1: a*b with latency check.
    single(1'b0, 18'sd3, 18'sd4, 18'sd5, -18'sd2, 64'sd23, 64'sd14);
    drain();

    // 2: a*conj(b), then alternate conj every beat.
    single(1'b1, 18'sd3, 18'sd4, 18'sd5, -18'sd2, 64'sd7, 64'sd26);
    drain();
    for (int n = 0; n < 8; n++) begin
      s_conj_i = n[0]; s_valid_i = 1'b1;
      cycle(acc);
    end
    drain();

    // 3: full negative range, no wrap; narrow instance clamps Q.
    single(1'b0, -18'sd131072, -18'sd131072, -18'sd131072, -18'sd131072, 64'sd0, 64'sd34359738368);
    chk("full_sat0", sat0, 0);
    chk("narrow_i", mi1, 0); chk("narrow_q", mq1, 131071); chk("narrow_sat", sat1, 1);
    chk("sh1_q", mq2, 64'sd17179869184); chk("sh1_sat", sat2, 0);
    drain();

    // 4: shift-by-one truncation versus rounding on +3 and -3.
    single(1'b0, 18'sd3, 18'sd0, 18'sd1, 18'sd0, 64'sd3, 64'sd0);
`ifdef CMULT_ROUND_EN
    chk("round_pos", mi2, 64'sd2);
`else
    chk("trunc_pos", mi2, 64'sd1);
`endif
    drain();
    single(1'b0, -18'sd3, 18'sd0, 18'sd1, 18'sd0, -64'sd3, 64'sd0);
`ifdef CMULT_ROUND_EN
    chk("round_neg", mi2, -64'sd1);
`else
    chk("trunc_neg", mi2, -64'sd2);
`endif
    drain();

    // 5: random stream of 10 with a 5-cycle downstream stall.
    sent = 0; saw_low = 1'b0;
    rand_data();
    for (int c = 0; c < 60 && (sent < 10 || sb.size() > 0); c++) begin
      m_ready_i = !(c >= 3 && c < 8);
      s_valid_i = (sent < 10);
      cycle(acc);
      if (s_valid_i && !acc) saw_low = 1'b1;
      if (acc) begin
        sent++;
        rand_data();
      end
    end
    chk("stream_sent", sent, 10);
    chk("ready_dropped", saw_low, 1);
    drain();

    // 6: asynchronous reset with samples in flight.
    sent = 0; m_ready_i = 1'b0;
    for (int n = 0; n < 10 && sent < 3; n++) begin
      rand_data();
      s_valid_i = 1'b1;
      cycle(acc);
      if (acc) sent++;
    end
    s_valid_i = 1'b0;
    chk("inflight_valid", mv0, 1);
    #3; arstn_i = 1'b0;
    #1;
    chk("arst_valid0", mv0, 0); chk("arst_valid1", mv1, 0); chk("arst_valid2", mv2, 0);
    chk("arst_i0", mi0, 0); chk("arst_sat1", sat1, 0);
    sb.delete(); occ = 0;
    #1; arstn_i = 1'b1;
    m_ready_i = 1'b1;
    for (int n = 0; n < 4; n++) begin
      chk("post_rst_idle", mv0, 0);
      cycle(acc);
    end
    single(1'b0, 18'sd3, 18'sd4, 18'sd5, -18'sd2, 64'sd23, 64'sd14);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
